iram_access_ctrl: RTL
=====================

Name: iram_access_ctrl

Overview:
Arbiter and access sequencer for the 8051 internal RAM/SFR byte array. It shares one registered-read, single-port RAM between the CPU core port (c_*) and the debug/loader port (d_*). It maps bit addresses to byte addresses and performs bit writes as read-modify-write sequences, so the RAM itself only ever sees byte reads and byte writes.

Parameters:
BIT_BASE, 8'h20, byte address of the bit-addressable region; bit addr < 0x80 maps to BIT_BASE + addr[6:3]
SFR_BIT_EN, 1, 1: bit addr >= 0x80 maps to {addr[7:3],3'b000}; 0: such bit ops complete with no RAM access, rbit=0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
c_req  in  1  core request, held until c_ack
c_wr  in  1  1=write, 0=read
c_bit  in  1  1=bit op, 0=byte op
c_addr  in  8  byte or bit address
c_wdata  in  8  byte write data
c_wbit  in  1  bit write value
c_ack  out  1  one-cycle completion pulse
c_rdata  out  8  byte read result
c_rbit  out  1  bit read result
d_req, d_wr, d_bit, d_addr, d_wdata, d_wbit, d_ack, d_rdata, d_rbit  same as c_* for debug port
ram_rd  out  1  RAM read strobe; ram_rdata valid next cycle
ram_wr  out  1  RAM write strobe
ram_addr  out  8  RAM byte address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; every output 0; last_grant=debug (so core wins first tie); served flags cleared. Reset overrides any in-flight sequence; a partial RMW is abandoned with no ram_wr issued.
- Four-phase handshake: requester raises req with stable fields and holds them until ack. Port's served flag sets on its ack and clears when its req is sampled low. A port with served=1 is not eligible.
- Arbitration, IDLE only: eligible = req & ~served. One eligible: grant it. Both eligible: grant the one != last_grant (round-robin). On grant, latch wr/bit/addr/wdata/wbit and owner, update last_grant.
- Address map: byte op -> addr. Bit op: addr < 0x80 -> BIT_BASE+addr[6:3]; addr >= 0x80 -> {addr[7:3],000} when SFR_BIT_EN; bit index = addr[2:0].
- States: IDLE, RD, CAP, WR, ACK.
- Byte read: IDLE -> RD (ram_rd=1) -> CAP (latch ram_rdata into owner rdata) -> ACK.
- Byte write: IDLE -> WR (ram_wr=1, ram_wdata=wdata) -> ACK.
- Bit read: same as byte read; CAP also sets owner rbit = ram_rdata[idx]; rdata gets the full byte.
- Bit write: IDLE -> RD -> CAP (latch byte) -> WR (ram_wdata = latched byte with bit idx replaced by wbit; other 7 bits unchanged) -> ACK.
- Bit op >= 0x80 with SFR_BIT_EN=0: IDLE -> ACK directly; rbit=0; rdata unchanged; no RAM strobe.
- ACK: owner ack=1 for exactly one cycle, then IDLE. The other port's ack stays 0.
- Latency, grant edge T to ack cycle: byte write T+2; byte/bit read T+3; bit write T+4.
- Outputs are registered. rdata/rbit hold until that port's next read completes.
- ram_rd and ram_wr are never both 1. Strobes are 0 outside RD/WR. ram_addr and ram_wdata are 0 in IDLE.
- A req dropped before ack is a protocol violation. The sequence still completes and acks.

Test Plan:
- Reset then byte write/read: core writes 8'h5A to 0x30 -> ram_wr with 0x30/0x5A at T+1, c_ack at T+2. Core reads 0x30 -> c_ack at T+3, c_rdata=8'h5A.
- Bit write low region: byte 0x21=8'h00; core bit-write addr 0x0B, wbit=1 -> RD 0x21, then WR 0x21 data 8'h08, c_ack at T+4. Bit read 0x0B -> c_rbit=1.
- SFR bit: byte 0x90=8'hFF; debug bit-write addr 0x93, wbit=0 -> ram_wdata 8'hF7 at 0x90. With SFR_BIT_EN=0, same op -> d_ack at T+1, no RAM strobe.
- Arbitration: c_req and d_req rise together after reset -> core first, debug next; repeated both-held requests alternate core/debug; a port holding req after ack is not regranted until it drops req.
- Reset mid bit-write: assert rst=0 in CAP -> next cycle all outputs 0, no ram_wr, busy=0; target byte unchanged.

Source files
------------

// File: rtl/iram_access_ctrl.sv
// iram_access_ctrl: shares one registered-read IRAM between core and debug ports,
// mapping bit addresses to bytes and doing bit writes as read-modify-write.
module iram_access_ctrl #(
  parameter logic [7:0] BIT_BASE   = 8'h20,
  parameter bit         SFR_BIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_req,
  input  logic       c_wr,
  input  logic       c_bit,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  input  logic       c_wbit,
  output logic       c_ack,
  output logic [7:0] c_rdata,
  output logic       c_rbit,
  input  logic       d_req,
  input  logic       d_wr,
  input  logic       d_bit,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  input  logic       d_wbit,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       d_rbit,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ACK} state_t;
  state_t state;
  logic own, last_d, served_c, served_d, wr_q, bit_q, wbit_q;
  logic [2:0] idx;
  logic elig_c, elig_d, gnt, gnt_d, sel_wr, sel_bit, sel_wbit, skip;
  logic [7:0] sel_addr, sel_wdata, map_addr, merged;
  always_comb begin
    elig_c    = c_req & ~served_c;
    elig_d    = d_req & ~served_d;
    gnt       = elig_c | elig_d;
    gnt_d     = elig_d & (~elig_c | ~last_d);
    sel_wr    = gnt_d ? d_wr : c_wr;
    sel_bit   = gnt_d ? d_bit : c_bit;
    sel_wbit  = gnt_d ? d_wbit : c_wbit;
    sel_addr  = gnt_d ? d_addr : c_addr;
    sel_wdata = gnt_d ? d_wdata : c_wdata;
    map_addr  = !sel_bit ? sel_addr :
                !sel_addr[7] ? BIT_BASE + {4'b0000, sel_addr[6:3]} : {sel_addr[7:3], 3'b000};
    skip      = sel_bit & sel_addr[7] & ~SFR_BIT_EN;
    merged    = ram_rdata;
    merged[idx] = wbit_q;
  end
  assign busy = (state != IDLE);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      own      <= 1'b0;
      last_d   <= 1'b1;
      served_c <= 1'b0;
      served_d <= 1'b0;
      wr_q     <= 1'b0;
      bit_q    <= 1'b0;
      wbit_q   <= 1'b0;
      idx      <= 3'd0;
      c_ack    <= 1'b0;
      c_rdata  <= 8'h00;
      c_rbit   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= 8'h00;
      d_rbit   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= 8'h00;
      ram_wdata <= 8'h00;
    end else begin
      c_ack    <= 1'b0;
      d_ack    <= 1'b0;
      served_c <= c_req & (served_c | c_ack);
      served_d <= d_req & (served_d | d_ack);
      case (state)
        IDLE: if (gnt) begin
          own    <= gnt_d;
          last_d <= gnt_d;
          wr_q   <= sel_wr;
          bit_q  <= sel_bit;
          wbit_q <= sel_wbit;
          idx    <= sel_addr[2:0];
          if (skip) begin
            state <= ACK;
            c_ack <= ~gnt_d;
            d_ack <= gnt_d;
            if (!sel_wr && !gnt_d) c_rbit <= 1'b0;
            if (!sel_wr && gnt_d) d_rbit <= 1'b0;
          end else if (sel_wr && !sel_bit) begin
            state     <= WR;
            ram_wr    <= 1'b1;
            ram_addr  <= map_addr;
            ram_wdata <= sel_wdata;
          end else begin
            state    <= RD;
            ram_rd   <= 1'b1;
            ram_addr <= map_addr;
          end
        end
        RD: begin
          ram_rd <= 1'b0;
          state  <= CAP;
        end
        // only bit writes reach CAP with wr_q set
        CAP: if (wr_q) begin
          state     <= WR;
          ram_wr    <= 1'b1;
          ram_wdata <= merged;
        end else begin
          state    <= ACK;
          ram_addr <= 8'h00;
          c_ack    <= ~own;
          d_ack    <= own;
          if (own) begin
            d_rdata <= ram_rdata;
            if (bit_q) d_rbit <= ram_rdata[idx];
          end else begin
            c_rdata <= ram_rdata;
            if (bit_q) c_rbit <= ram_rdata[idx];
          end
        end
        WR: begin
          state     <= ACK;
          ram_wr    <= 1'b0;
          ram_addr  <= 8'h00;
          ram_wdata <= 8'h00;
          c_ack     <= ~own;
          d_ack     <= own;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
